// File: rtl/q_value_updater_pkg.sv
// ============================================================================
// Module : q_value_updater_pkg
// Purpose: Shared Q-learning definitions for the Q-table write side and the
//          policy generator. Provides row/lane geometry, fixed-point format
//          constants, the updater FSM encoding and lane/saturation helpers.
//          Q values are signed Q8.8; alpha and gamma are unsigned Q0.16.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package q_value_updater_pkg;

  localparam int Q_W   = 16;            // Q value width, signed Q8.8
  localparam int N_ACT = 4;             // actions per row, fixed by the row width
  localparam int ROW_W = Q_W * N_ACT;   // 64-bit Q-table row

  localparam int c_Q016_FRAC = 16;      // fraction bits of alpha / gamma
  localparam int c_TD_W      = 18;      // TD error width, cannot overflow
  localparam int c_SUM_W     = 20;      // pre-saturation update width

  localparam logic signed [Q_W-1:0] c_Q_MAX = 16'sh7FFF;
  localparam logic signed [Q_W-1:0] c_Q_MIN = 16'sh8000;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RD_S  = 4'd1,
    S_RD_NS = 4'd2,
    S_WAIT  = 4'd3,
    S_MAXQ  = 4'd4,
    S_TD    = 4'd5,
    S_UPD   = 4'd6,
    S_WR    = 4'd7,
    S_DONE  = 4'd8
  } upd_state_t;

  // Lane k of a row occupies bits [16k+15:16k].
  function automatic logic signed [Q_W-1:0] lane(input logic [ROW_W-1:0] row,
                                                 input int k);
    return row[k*Q_W +: Q_W];
  endfunction

  // Clamp a wide signed value into the Q8.8 range.
  function automatic logic signed [Q_W-1:0] sat16(input logic signed [c_SUM_W-1:0] x);
    logic signed [c_SUM_W-1:0] hi;
    logic signed [c_SUM_W-1:0] lo;
    hi = c_SUM_W'(c_Q_MAX);
    lo = c_SUM_W'(c_Q_MIN);
    if (x > hi)      return c_Q_MAX;
    else if (x < lo) return c_Q_MIN;
    else             return x[Q_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/q_value_updater_row_max.sv
// ============================================================================
// Module : q_row_max
// Purpose: Combinational signed maximum over the four Q8.8 lanes of a row.
//          Ties resolve to the lowest lane.
// Ports  : i_row  in  ROW_W  Q-table row
//          o_max  out Q_W    largest signed lane value
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module q_row_max
  import q_value_updater_pkg::*;
(
  input  logic [ROW_W-1:0]      i_row,
  output logic signed [Q_W-1:0] o_max
);

  logic signed [Q_W-1:0] w_best;

  always_comb begin
    w_best = lane(i_row, 0);
    for (int k = 1; k < N_ACT; k++) begin
      if (lane(i_row, k) > w_best) w_best = lane(i_row, k);
    end
  end

  assign o_max = w_best;

endmodule

`default_nettype wire

// File: rtl/q_value_updater.sv
// ============================================================================
// Module : q_value_updater
// Purpose: Applies one Q-learning update per request:
//          Q(s,a) <= sat16(Q(s,a) + alpha*(r + gamma*max Q(s',.) - Q(s,a))).
//          Reads rows s and s', writes row s back with lane a replaced.
// Ports  : clk, rst_n            clock, synchronous active-low reset
//          i_start               request, sampled only in IDLE
//          i_state/i_next_state  s / s' row indices
//          i_action              lane index, legal 0..3
//          i_reward              r, signed Q8.8
//          i_terminal            s' terminal: discounted term is zero
//          i_alpha/i_gamma       unsigned Q0.16 rates
//          o_rd_en/o_rd_addr     Q-table read, data on i_rd_data one cycle later
//          o_wr_en/o_wr_addr/o_wr_data  single-cycle row write
//          o_busy, o_done, o_err status (err sticky until next accepted start)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module q_value_updater
  import q_value_updater_pkg::*;
#(
  parameter int ST_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ST_W-1:0]   i_state,
  input  logic [ST_W-1:0]   i_next_state,
  input  logic [3:0]        i_action,
  input  logic [Q_W-1:0]    i_reward,
  input  logic              i_terminal,
  input  logic [15:0]       i_alpha,
  input  logic [15:0]       i_gamma,
  output logic              o_rd_en,
  output logic [ST_W-1:0]   o_rd_addr,
  input  logic [ROW_W-1:0]  i_rd_data,
  output logic              o_wr_en,
  output logic [ST_W-1:0]   o_wr_addr,
  output logic [ROW_W-1:0]  o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  upd_state_t r_state;
  upd_state_t w_nxt;

  // captured request
  logic [ST_W-1:0]        r_s;
  logic [ST_W-1:0]        r_ns;
  logic [3:0]             r_act;
  logic signed [Q_W-1:0]  r_reward;
  logic                   r_term;
  logic [15:0]            r_alpha;
  logic [15:0]            r_gamma;

  // datapath
  logic [ROW_W-1:0]        r_row_s;
  logic [ROW_W-1:0]        r_row_ns;
  logic signed [Q_W-1:0]   r_m;
  logic signed [c_TD_W-1:0] r_td;

  // registered outputs
  logic              r_rd_en;
  logic [ST_W-1:0]   r_rd_addr;
  logic              r_wr_en;
  logic [ST_W-1:0]   r_wr_addr;
  logic [ROW_W-1:0]  r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic                      w_act_ok;
  logic signed [Q_W-1:0]     w_max;
  logic signed [Q_W-1:0]     w_q_sa;
  logic signed [32:0]        w_gm;
  logic signed [16:0]        w_gm_q;
  logic signed [c_TD_W-1:0]  w_td;
  logic signed [34:0]        w_at;
  logic signed [18:0]        w_at_q;
  logic signed [c_SUM_W-1:0] w_sum;
  logic signed [Q_W-1:0]     w_new;
  logic [ROW_W-1:0]          w_merged;

  q_row_max u_row_max (
    .i_row (r_row_ns),
    .o_max (w_max)
  );

  assign w_act_ok = (r_act < 4'd4);
  assign w_q_sa   = lane(r_row_s, int'(r_act[1:0]));

  // Unsigned Q0.16 rates are zero-extended to keep the products signed;
  // the arithmetic shift gives round-toward-minus-infinity.
  assign w_gm   = 33'($signed({1'b0, r_gamma})) * 33'(r_m);
  assign w_gm_q = 17'(w_gm >>> c_Q016_FRAC);
  assign w_td   = c_TD_W'(r_reward) + c_TD_W'(w_gm_q) - c_TD_W'(w_q_sa);

  assign w_at   = 35'($signed({1'b0, r_alpha})) * 35'(r_td);
  assign w_at_q = 19'(w_at >>> c_Q016_FRAC);
  assign w_sum  = c_SUM_W'(w_q_sa) + c_SUM_W'(w_at_q);
  assign w_new  = sat16(w_sum);

  always_comb begin
    w_merged = r_row_s;
    w_merged[int'(r_act[1:0])*Q_W +: Q_W] = w_new;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_nxt = S_RD_S;
      S_RD_S:  w_nxt = w_act_ok ? S_RD_NS : S_DONE;
      S_RD_NS: w_nxt = S_WAIT;
      S_WAIT:  w_nxt = S_MAXQ;
      S_MAXQ:  w_nxt = S_TD;
      S_TD:    w_nxt = S_UPD;
      S_UPD:   w_nxt = S_WR;
      S_WR:    w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------ datapath and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s       <= '0;
      r_ns      <= '0;
      r_act     <= '0;
      r_reward  <= '0;
      r_term    <= 1'b0;
      r_alpha   <= '0;
      r_gamma   <= '0;
      r_row_s   <= '0;
      r_row_ns  <= '0;
      r_m       <= '0;
      r_td      <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= (w_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_s      <= i_state;
            r_ns     <= i_next_state;
            r_act    <= i_action;
            r_reward <= i_reward;
            r_term   <= i_terminal;
            r_alpha  <= i_alpha;
            r_gamma  <= i_gamma;
            r_err    <= 1'b0;
            // an illegal action never touches the table
            if (i_action < 4'd4) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= i_state;
            end
          end
        end
        S_RD_S: begin
          if (w_act_ok) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_ns;
          end else begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
          end
        end
        S_RD_NS: r_row_s  <= i_rd_data;
        S_WAIT:  r_row_ns <= i_rd_data;
        S_MAXQ:  r_m      <= r_term ? '0 : w_max;
        S_TD:    r_td     <= w_td;
        S_UPD: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_s;
          r_wr_data <= w_merged;
        end
        S_WR:    r_done   <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;

endmodule

`default_nettype wire
